choose_pivot_row_par: RTL and testbench

Parametrised successor to the simplex ratio-test block. It streams the pivot column and the right-hand-side column of the tableau, LANES rows per beat, and picks the leaving row. The leaving row is the row with minimum rhs/piv among rows with piv > 0. Ratios are compared exactly by signed cross-multiplication, so no divider is needed. Sits between the pivot-column selector and the tableau-update engine; its cont/terminate outputs drive the top-level simplex FSM.

---
 rtl/lp_pkg.sv | 22 ++
 rtl/choose_pivot_row_par_if.sv | 33 +++
 rtl/ratio_less.sv | 42 ++++
 rtl/choose_pivot_row_par.sv | 184 ++++++++++++++++++
 tb/tb_choose_pivot_row_par.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lp_pkg.sv
// rtl/lp_pkg.sv - shared defaults, types and FSM encoding for the simplex ratio-test blocks
//
// Contents:
//   DEF_ELEMW / DEF_IDXW : default element width and row-index width
//   elem_t / prod_t      : signed element and full-width product at the default width
//   state_t              : ratio-test controller states
package lp_pkg;

    localparam int DEF_ELEMW = 32;
    localparam int DEF_IDXW  = 16;

    typedef logic signed [DEF_ELEMW-1:0]   elem_t;
    typedef logic signed [2*DEF_ELEMW-1:0] prod_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/choose_pivot_row_par_if.sv
// rtl/choose_pivot_row_par_if.sv - joined pivot-column / RHS-column beat stream
//
// Signals:
//   axi_pivotcol_data/valid/ready : pivot-column beat, LANES elements, lane 0 = lowest row
//   axi_rightcol_data/valid/ready : RHS beat, lane-aligned with the pivot column
// Modports:
//   master : stream source (drives data/valid, observes ready)
//   slave  : ratio-test block (observes data/valid, drives ready)
interface choose_pivot_row_par_if #(
    parameter int ELEMW = 32,
    parameter int LANES = 1
);

    logic [LANES*ELEMW-1:0] axi_pivotcol_data;
    logic                   axi_pivotcol_valid;
    logic                   axi_pivotcol_ready;
    logic [LANES*ELEMW-1:0] axi_rightcol_data;
    logic                   axi_rightcol_valid;
    logic                   axi_rightcol_ready;

    modport master (
        output axi_pivotcol_data, axi_pivotcol_valid,
        output axi_rightcol_data, axi_rightcol_valid,
        input  axi_pivotcol_ready, axi_rightcol_ready
    );

    modport slave (
        input  axi_pivotcol_data, axi_pivotcol_valid,
        input  axi_rightcol_data, axi_rightcol_valid,
        output axi_pivotcol_ready, axi_rightcol_ready
    );

endinterface

// File: rtl/ratio_less.sv
// rtl/ratio_less.sv - one link of the ratio-test chain: does the candidate row replace the best?
//
// Ports:
//   en         : candidate lane holds a real row
//   cand_rhs/p : candidate RHS and pivot-column values
//   best_rhs/p : running best RHS and pivot-column values
//   best_valid : running best holds an eligible row
//   take       : candidate is eligible and strictly better than the best
module ratio_less
    import lp_pkg::*;
#(
    parameter int W = DEF_ELEMW
) (
    input  logic                en,
    input  logic signed [W-1:0] cand_rhs,
    input  logic signed [W-1:0] cand_piv,
    input  logic signed [W-1:0] best_rhs,
    input  logic signed [W-1:0] best_piv,
    input  logic                best_valid,
    output logic                take
);

    logic signed [2*W-1:0] c_rhs_x, c_piv_x, b_rhs_x, b_piv_x;
    logic signed [2*W-1:0] lhs, rhs;
    logic                  eligible;

    // Sign-extend before multiplying so the full 2W product is exact.
    assign c_rhs_x = {{W{cand_rhs[W-1]}}, cand_rhs};
    assign c_piv_x = {{W{cand_piv[W-1]}}, cand_piv};
    assign b_rhs_x = {{W{best_rhs[W-1]}}, best_rhs};
    assign b_piv_x = {{W{best_piv[W-1]}}, best_piv};

    // r/p < br/bp  <=>  r*bp < br*p, valid because both pivots are positive.
    assign lhs = c_rhs_x * b_piv_x;
    assign rhs = b_rhs_x * c_piv_x;

    assign eligible = en && !cand_piv[W-1] && (cand_piv != '0);

    // Strict less-than keeps the earlier row on a tie.
    assign take = eligible && (!best_valid || (lhs < rhs));

endmodule

// File: rtl/choose_pivot_row_par.sv
// rtl/choose_pivot_row_par.sv - simplex ratio test: picks the leaving row, LANES rows per beat
//
// Ports:
//   clk, areset  : clock, synchronous active-high reset
//   start        : one-cycle pulse, honoured in IDLE only; num_rows sampled with it
//   num_rows     : rows to scan (0 gives an immediate terminate)
//   col          : joined pivot-column / RHS stream (slave side)
//   busy         : high whenever the controller is not IDLE
//   cont         : one-cycle pulse, an eligible pivot row was found
//   terminate    : one-cycle pulse, no row has a positive pivot (unbounded LP)
//   pivot_row    : winning row index, held until the next result
//   pivot_elem   : pivot-column value of the winning row
module choose_pivot_row_par
    import lp_pkg::*;
#(
    parameter int ELEMW = DEF_ELEMW,
    parameter int LANES = 1,
    parameter int IDXW  = DEF_IDXW
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    start,
    input  logic [IDXW-1:0]         num_rows,
    choose_pivot_row_par_if.slave   col,
    output logic                    busy,
    output logic                    cont,
    output logic                    terminate,
    output logic [IDXW-1:0]         pivot_row,
    output logic signed [ELEMW-1:0] pivot_elem
);

    // One extra bit so base + LANES cannot wrap near the top of the index range.
    localparam int BW = IDXW + 1;

    state_t                  state;
    logic                    ready;
    logic [IDXW-1:0]         n_rows;
    logic [BW-1:0]           base;
    logic                    accept;
    logic                    last_beat;
    logic [LANES-1:0]        lane_en;

    logic                    s1_valid;
    logic signed [ELEMW-1:0] s1_rhs [LANES];
    logic signed [ELEMW-1:0] s1_piv [LANES];
    logic [IDXW-1:0]         s1_idx [LANES];
    logic [LANES-1:0]        s1_en;

    logic                    best_valid;
    logic signed [ELEMW-1:0] b_rhs;
    logic signed [ELEMW-1:0] b_piv;
    logic [IDXW-1:0]         b_idx;

    assign col.axi_pivotcol_ready = ready;
    assign col.axi_rightcol_ready = ready;
    assign accept    = ready && col.axi_pivotcol_valid && col.axi_rightcol_valid;
    assign last_beat = (base + BW'(LANES)) >= {1'b0, n_rows};

    always_comb begin
        lane_en = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_en[l] = (base + BW'(l)) < {1'b0, n_rows};
        end
    end

    // Lane-ordered compare chain: lane 0 challenges the running best first.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic                    in_valid, out_valid, take;
        logic signed [ELEMW-1:0] in_rhs, in_piv, out_rhs, out_piv;
        logic [IDXW-1:0]         in_idx, out_idx;

        if (l == 0) begin : g_head
            assign in_valid = best_valid;
            assign in_rhs   = b_rhs;
            assign in_piv   = b_piv;
            assign in_idx   = b_idx;
        end else begin : g_link
            assign in_valid = g_lane[l-1].out_valid;
            assign in_rhs   = g_lane[l-1].out_rhs;
            assign in_piv   = g_lane[l-1].out_piv;
            assign in_idx   = g_lane[l-1].out_idx;
        end

        ratio_less #(.W(ELEMW)) u_cmp (
            .en         (s1_en[l]),
            .cand_rhs   (s1_rhs[l]),
            .cand_piv   (s1_piv[l]),
            .best_rhs   (in_rhs),
            .best_piv   (in_piv),
            .best_valid (in_valid),
            .take       (take)
        );

        assign out_valid = in_valid | take;
        assign out_rhs   = take ? s1_rhs[l] : in_rhs;
        assign out_piv   = take ? s1_piv[l] : in_piv;
        assign out_idx   = take ? s1_idx[l] : in_idx;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state      <= ST_IDLE;
            ready      <= 1'b0;
            busy       <= 1'b0;
            cont       <= 1'b0;
            terminate  <= 1'b0;
            pivot_row  <= '0;
            pivot_elem <= '0;
            n_rows     <= '0;
            base       <= '0;
            s1_valid   <= 1'b0;
            s1_en      <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_rhs[l] <= '0;
                s1_piv[l] <= '0;
                s1_idx[l] <= '0;
            end
            best_valid <= 1'b0;
            b_rhs      <= '0;
            b_piv      <= '0;
            b_idx      <= '0;
        end else begin
            // Stage 1: capture the accepted beat.
            s1_valid <= accept;
            if (accept) begin
                for (int l = 0; l < LANES; l++) begin
                    s1_piv[l] <= col.axi_pivotcol_data[l*ELEMW +: ELEMW];
                    s1_rhs[l] <= col.axi_rightcol_data[l*ELEMW +: ELEMW];
                    s1_idx[l] <= base[IDXW-1:0] + IDXW'(l);
                end
                s1_en <= lane_en;
                base  <= base + BW'(LANES);
            end

            // Stage 2: fold the captured beat into the running best.
            if (s1_valid) begin
                best_valid <= g_lane[LANES-1].out_valid;
                b_rhs      <= g_lane[LANES-1].out_rhs;
                b_piv      <= g_lane[LANES-1].out_piv;
                b_idx      <= g_lane[LANES-1].out_idx;
            end

            cont      <= 1'b0;
            terminate <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_rows     <= num_rows;
                        base       <= '0;
                        best_valid <= 1'b0;
                        busy       <= 1'b1;
                        if (num_rows == '0) begin
                            state <= ST_FIN;
                        end else begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept && last_beat) begin
                        ready <= 1'b0;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Last beat is in stage 2 now; best is final after this edge.
                    state <= ST_FIN;
                end
                ST_FIN: begin
                    cont       <= best_valid;
                    terminate  <= !best_valid;
                    pivot_row  <= best_valid ? b_idx : '0;
                    pivot_elem <= best_valid ? b_piv : '0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_choose_pivot_row_par.sv
// tb/tb_choose_pivot_row_par.sv - self-checking bench for choose_pivot_row_par (LANES=1 and LANES=4)
module tb_choose_pivot_row_par;
    import lp_pkg::*;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Common stimulus, routed to one of the two instances by sel4.
    bit           sel4 = 1'b0;
    logic         t_start = 1'b0;
    logic [15:0]  t_nrows = '0;
    logic [127:0] t_pdata = '0;
    logic [127:0] t_rdata = '0;
    logic         t_pv = 1'b0;
    logic         t_rv = 1'b0;

    elem_t pmem [64];
    elem_t rmem [64];

    logic        busy1, cont1, term1, busy4, cont4, term4;
    logic [15:0] row1, row4;
    elem_t       elem1, elem4;

    choose_pivot_row_par_if #(.ELEMW(32), .LANES(1)) if1 ();
    choose_pivot_row_par_if #(.ELEMW(32), .LANES(4)) if4 ();

    assign if1.axi_pivotcol_data  = t_pdata[31:0];
    assign if1.axi_rightcol_data  = t_rdata[31:0];
    assign if1.axi_pivotcol_valid = !sel4 && t_pv;
    assign if1.axi_rightcol_valid = !sel4 && t_rv;
    assign if4.axi_pivotcol_data  = t_pdata;
    assign if4.axi_rightcol_data  = t_rdata;
    assign if4.axi_pivotcol_valid = sel4 && t_pv;
    assign if4.axi_rightcol_valid = sel4 && t_rv;

    choose_pivot_row_par #(.ELEMW(32), .LANES(1), .IDXW(16)) dut1 (
        .clk        (clk),
        .areset     (areset),
        .start      (!sel4 && t_start),
        .num_rows   (t_nrows),
        .col        (if1),
        .busy       (busy1),
        .cont       (cont1),
        .terminate  (term1),
        .pivot_row  (row1),
        .pivot_elem (elem1)
    );

    choose_pivot_row_par #(.ELEMW(32), .LANES(4), .IDXW(16)) dut4 (
        .clk        (clk),
        .areset     (areset),
        .start      (sel4 && t_start),
        .num_rows   (t_nrows),
        .col        (if4),
        .busy       (busy4),
        .cont       (cont4),
        .terminate  (term4),
        .pivot_row  (row4),
        .pivot_elem (elem4)
    );

    logic        m_busy, m_cont, m_term, m_ready, m_rready;
    logic [15:0] m_row;
    elem_t       m_elem;
    assign m_busy   = sel4 ? busy4 : busy1;
    assign m_cont   = sel4 ? cont4 : cont1;
    assign m_term   = sel4 ? term4 : term1;
    assign m_row    = sel4 ? row4  : row1;
    assign m_elem   = sel4 ? elem4 : elem1;
    assign m_ready  = sel4 ? if4.axi_pivotcol_ready : if1.axi_pivotcol_ready;
    assign m_rready = sel4 ? if4.axi_rightcol_ready : if1.axi_rightcol_ready;

    // Reference: minimum rhs/piv over rows with piv > 0, then the lowest row reaching it.
    task automatic model(input int n, output bit found, output int row, output elem_t elem);
        prod_t br, bp;
        found = 1'b0; row = 0; elem = '0; br = '0; bp = 64'sd1;
        for (int i = 0; i < n; i++) begin
            if (pmem[i] > 0) begin
                if (!found || (prod_t'(rmem[i]) * bp < br * prod_t'(pmem[i]))) begin
                    found = 1'b1;
                    br = prod_t'(rmem[i]);
                    bp = prod_t'(pmem[i]);
                end
            end
        end
        if (found) begin
            for (int i = 0; i < n; i++) begin
                if (pmem[i] > 0 && (prod_t'(rmem[i]) * bp == br * prod_t'(pmem[i]))) begin
                    row = i;
                    elem = pmem[i];
                    break;
                end
            end
        end
    endtask

    task automatic load_rows(input int n, input int piv [], input int rhs []);
        for (int i = 0; i < 64; i++) begin
            pmem[i] = elem_t'(1);
            rmem[i] = elem_t'(-100);
        end
        for (int i = 0; i < n; i++) begin
            pmem[i] = elem_t'(piv[i]);
            rmem[i] = elem_t'(rhs[i]);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(3, 0) == 0) pmem[i] = elem_t'($urandom);
            else                           pmem[i] = elem_t'(int'($urandom_range(14, 0)) - 4);
            if ($urandom_range(3, 0) == 0) rmem[i] = elem_t'($urandom);
            else                           rmem[i] = elem_t'(int'($urandom_range(30, 0)) - 6);
        end
    endtask

    // Runs one selection; abort_beats >= 0 resets the DUT after that many beats.
    task automatic run_scan(input bit l4, input int n, input int stall, input int gap_max,
                            input int abort_beats, input string tag);
        int    lanes, beats, k, row_e;
        bit    found_e, acc, seen, timed_out;
        elem_t elem_e;
        lanes = l4 ? 4 : 1;
        beats = (n + lanes - 1) / lanes;
        model(n, found_e, row_e, elem_e);
        sel4 = l4;
        t_nrows = 16'(n);
        t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        n_vec++;
        if (m_busy !== 1'b1) begin
            n_err++; $display("FAIL %s busy_after_start: got %b want 1", tag, m_busy);
        end
        timed_out = 1'b0;
        for (int b = 0; b < beats; b++) begin
            if (b == abort_beats) begin
                t_pv = 1'b0; t_rv = 1'b0;
                areset = 1'b1;
                @(posedge clk); #1;
                areset = 1'b0;
                n_vec++;
                if ({m_busy, m_cont, m_term, m_ready, m_row, m_elem} !== '0) begin
                    n_err++;
                    $display("FAIL %s reset_outputs: got busy=%b cont=%b term=%b ready=%b row=%0d elem=%0d want all 0",
                             tag, m_busy, m_cont, m_term, m_ready, m_row, m_elem);
                end
                seen = 1'b0;
                repeat (6) begin
                    @(posedge clk); #1;
                    seen = seen | m_cont | m_term;
                end
                n_vec++;
                if (seen !== 1'b0) begin
                    n_err++; $display("FAIL %s pulse_after_abort: got %b want 0", tag, seen);
                end
                return;
            end
            if (gap_max > 0) begin
                t_pv = 1'b0; t_rv = 1'b0;
                repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
            end
            t_pdata = '0; t_rdata = '0;
            for (int l = 0; l < lanes; l++) begin
                t_pdata[l*32 +: 32] = pmem[b*lanes + l];
                t_rdata[l*32 +: 32] = rmem[b*lanes + l];
            end
            t_pv = 1'b1;
            t_rv = (b == 0 && stall > 0) ? 1'b0 : 1'b1;
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    n_vec++;
                    if (m_ready !== 1'b1 || m_rready !== 1'b1) begin
                        n_err++; $display("FAIL %s stall_ready: got %b/%b want 1/1 (stall cycle %0d)",
                                          tag, m_ready, m_rready, s);
                    end
                end
            end
            t_rv = 1'b1;
            acc = 1'b0; k = 0;
            while (!acc && k < 50) begin
                acc = m_ready;
                @(posedge clk); #1;
                k++;
            end
            if (!acc) begin
                timed_out = 1'b1;
                break;
            end
        end
        t_pv = 1'b0; t_rv = 1'b0;
        n_vec++;
        if (timed_out) begin
            n_err++; $display("FAIL %s beat_accept: got timeout want accept within 50 cycles", tag);
        end
        k = 0; seen = 1'b0;
        while (!seen && k < 10) begin
            @(posedge clk); #1;
            k++;
            seen = m_cont | m_term;
        end
        n_vec++;
        if (k !== ((n == 0) ? 1 : 2)) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", tag, k, (n == 0) ? 1 : 2);
        end
        n_vec++;
        if (m_cont !== found_e || m_term !== !found_e) begin
            n_err++; $display("FAIL %s cont_term: got %b/%b want %b/%b", tag, m_cont, m_term, found_e, !found_e);
        end
        n_vec++;
        if (m_row !== 16'(row_e) || m_elem !== elem_e) begin
            n_err++; $display("FAIL %s result: got row=%0d elem=%0d want row=%0d elem=%0d",
                              tag, m_row, m_elem, row_e, elem_e);
        end
        @(posedge clk); #1;
        n_vec++;
        if (m_cont !== 1'b0 || m_term !== 1'b0 || m_busy !== 1'b0 || m_row !== 16'(row_e)) begin
            n_err++; $display("FAIL %s after_pulse: got cont=%b term=%b busy=%b row=%0d want 0/0/0 row=%0d",
                              tag, m_cont, m_term, m_busy, m_row, row_e);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel4 = (s == 1);
            #1;
            n_vec++;
            if ({m_busy, m_cont, m_term, m_ready, m_rready, m_row, m_elem} !== '0) begin
                n_err++;
                $display("FAIL reset_state lanes=%0d: got busy=%b cont=%b term=%b ready=%b row=%0d elem=%0d want all 0",
                         s ? 4 : 1, m_busy, m_cont, m_term, m_ready, m_row, m_elem);
            end
        end
    endtask

    task automatic test_basic();
        load_rows(4, '{2, 4, 1, -1}, '{8, 8, 3, 1});
        run_scan(1'b0, 4, 0, 0, -1, "basic");
        n_vec++;
        if (row1 !== 16'd1 || elem1 !== 32'sd4) begin
            n_err++; $display("FAIL basic_plan: got row=%0d elem=%0d want row=1 elem=4", row1, elem1);
        end
    endtask

    task automatic test_tie();
        load_rows(3, '{2, 1, 3}, '{4, 2, 9});
        run_scan(1'b0, 3, 0, 0, -1, "tie");
        n_vec++;
        if (row1 !== 16'd0) begin
            n_err++; $display("FAIL tie_lowest_index: got %0d want 0", row1);
        end
    endtask

    task automatic test_no_eligible();
        load_rows(3, '{0, -3, -1}, '{5, -6, 2});
        run_scan(1'b0, 3, 0, 0, -1, "no_eligible");
    endtask

    task automatic test_partial_beat();
        load_rows(8, '{1, 2, -1, 5, 4, 1, 1, 1}, '{9, 10, 1, 30, 4, 0, -100, -100});
        run_scan(1'b1, 6, 0, 0, -1, "partial_beat");
        n_vec++;
        if (row4 !== 16'd5 || elem4 !== 32'sd1) begin
            n_err++; $display("FAIL partial_beat_plan: got row=%0d elem=%0d want row=5 elem=1", row4, elem4);
        end
    endtask

    task automatic test_backpressure();
        load_rows(4, '{2, 4, 1, -1}, '{8, 8, 3, 1});
        run_scan(1'b0, 4, 3, 0, -1, "backpressure_l1");
        load_rows(8, '{1, 2, -1, 5, 4, 1, 1, 1}, '{9, 10, 1, 30, 4, 0, -100, -100});
        run_scan(1'b1, 6, 3, 0, -1, "backpressure_l4");
    endtask

    task automatic test_zero_rows();
        run_scan(1'b0, 0, 0, 0, -1, "zero_rows_l1");
        run_scan(1'b1, 0, 0, 0, -1, "zero_rows_l4");
    endtask

    task automatic test_reset_mid_run();
        load_rows(4, '{2, 4, 1, -1}, '{8, 8, 3, 1});
        run_scan(1'b0, 4, 0, 0, -1, "pre_abort");
        load_rows(4, '{1, 1, 5, 5}, '{0, 1, 1, 1});
        run_scan(1'b0, 4, 0, 0, 2, "abort_l1");
        load_rows(4, '{3, 1, 2, 9}, '{9, 5, 2, 18});
        run_scan(1'b0, 4, 0, 0, -1, "after_abort_l1");
        load_rows(16, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1},
                      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        run_scan(1'b1, 16, 0, 0, 2, "abort_l4");
        load_rows(5, '{-2, 7, 2, 0, 3}, '{1, 14, 6, 0, 3});
        run_scan(1'b1, 5, 0, 0, -1, "after_abort_l4");
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            fill_random();
            run_scan(1'($urandom_range(1, 0)), int'($urandom_range(24, 1)), 0, 2, -1, $sformatf("random_%0d", it));
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 6; it++) begin
            fill_random();
            run_scan(it[0], int'($urandom_range(12, 1)), 0, 0, -1, $sformatf("b2b_%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_no_eligible();
        test_partial_beat();
        test_backpressure();
        test_zero_rows();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2000000 time units");
        $fatal(1);
    end

endmodule
